// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module   : pwm_pkg
// Purpose  : Shared definitions for the PWM tile: duty-code width common to
//            the generator and the decoder, and the decoder's measurement
//            state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

    // Duty code width; must match the generator's control code width.
    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // not armed, waiting for the first rising edge
        HIGH  = 2'd1,   // input high, counting period and high time
        LOW   = 2'd2,   // input low, counting period only
        STUCK = 2'd3    // no rising edge for the full counter range
    } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_div_restoring.sv
//------------------------------------------------------------------------------
// Module   : pwm_div_restoring
// Purpose  : Restoring divider computing floor({num_hi, DUTY_W'b0} / den),
//            one quotient bit per cycle. The caller guarantees num_hi < den,
//            so the quotient always fits in DUTY_W bits.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_abort       - drops any division in flight
//            i_start       - load operands (ignored while busy)
//            i_num_hi      - upper part of the numerator
//            i_den         - denominator
//            o_busy        - iterating (DUTY_W cycles after the load)
//            o_done        - high in the final iteration cycle
//            o_quot        - quotient, complete while o_done is high
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_div_restoring
    import pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_abort,
    input  logic              i_start,
    input  logic [CW-1:0]     i_num_hi,
    input  logic [CW-1:0]     i_den,
    output logic              o_busy,
    output logic              o_done,
    output logic [DUTY_W-1:0] o_quot
);

    localparam int                 c_cnt_w   = $clog2(DUTY_W + 1);
    localparam logic [c_cnt_w-1:0] c_iters   = c_cnt_w'(DUTY_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [CW-1:0]     r_rem;
    logic [CW-1:0]     r_den;
    logic [DUTY_W-2:0] r_quot;
    logic [c_cnt_w-1:0] r_cnt;
    logic              r_busy;

    logic [CW:0]       w_shift;
    logic [CW-1:0]     w_diff;
    logic              w_ge;
    logic              w_last;
    logic [DUTY_W-1:0] w_quot_next;

    // Low numerator bits are all zero, so each step shifts in a 0.
    // The remainder stays below den, so the difference fits in CW bits.
    assign w_shift     = {r_rem, 1'b0};
    assign w_ge        = (w_shift >= {1'b0, r_den});
    assign w_diff      = w_shift[CW-1:0] - r_den;
    assign w_last      = r_busy && (r_cnt == c_cnt_one);
    assign w_quot_next = {r_quot, w_ge};

    assign o_busy = r_busy;
    assign o_done = w_last && !i_abort;
    assign o_quot = w_quot_next;

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= c_iters;
                r_rem  <= i_num_hi;
                r_den  <= i_den;
                r_quot <= '0;
            end
        end else begin
            r_rem  <= w_ge ? w_diff : w_shift[CW-1:0];
            r_quot <= w_quot_next[DUTY_W-2:0];
            r_cnt  <= r_cnt - c_cnt_one;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
//------------------------------------------------------------------------------
// Module   : pwm_duty_decoder
// Purpose  : Measures an incoming PWM waveform and recovers its duty code
//            floor(high*256/period), plus period and high time in clk cycles.
// Ports    : clk        - clock
//            rst_n      - synchronous reset, active HIGH despite the name
//            ena        - 0 halts measurement and returns to IDLE
//            pwm_in     - asynchronous PWM input
//            duty       - recovered duty code
//            period     - last measured period (cycles)
//            high_time  - last measured high time (cycles)
//            valid      - one-cycle pulse when the outputs above update
//            busy       - divider running
//            timeout    - no rising edge for 2**CW-1 cycles
//            overrun    - sticky: a period was dropped while the divider ran
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CW-1:0]     period,
    output logic [CW-1:0]     high_time,
    output logic              valid,
    output logic              busy,
    output logic              timeout,
    output logic              overrun
);

    // Counter saturation value minus one: reaching it this cycle means the
    // counter shows 2**CW-1 in the same cycle the timeout is reported.
    localparam logic [CW-1:0] c_cnt_pre_max = {{(CW-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] c_cnt_one     = {{(CW-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_q;
    pwm_state_t             r_state;
    pwm_state_t             w_state_next;
    logic [CW-1:0]          r_pcnt;
    logic [CW-1:0]          r_hcnt;
    logic [CW-1:0]          r_pend_p;
    logic [CW-1:0]          r_pend_h;
    logic [DUTY_W-1:0]      r_duty;
    logic [CW-1:0]          r_period;
    logic [CW-1:0]          r_high;
    logic                   r_valid;
    logic                   r_timeout;
    logic                   r_overrun;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_pcnt_sat;
    logic                   w_meas;
    logic                   w_sat;
    logic                   w_div_start;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [DUTY_W-1:0]      w_div_quot;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s && !r_s_q;
    assign w_fall     = !w_s && r_s_q;
    assign w_pcnt_sat = (r_pcnt == c_cnt_pre_max);

    // A completed period is only handed to the divider when it is free.
    assign w_div_start = w_meas && !w_div_busy;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync <= '0;
            r_s_q  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_q  <= w_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_meas       = 1'b0;
        w_sat        = 1'b0;
        if (!ena) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // First edge only arms the measurement.
                    if (w_rise) begin
                        w_state_next = HIGH;
                    end
                end
                HIGH: begin
                    if (w_pcnt_sat) begin
                        w_state_next = STUCK;
                        w_sat        = 1'b1;
                    end else if (w_fall) begin
                        w_state_next = LOW;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_next = HIGH;
                        w_meas       = 1'b1;
                    end else if (w_pcnt_sat) begin
                        w_state_next = STUCK;
                        w_sat        = 1'b1;
                    end
                end
                STUCK: begin
                    if (w_rise) begin
                        w_state_next = HIGH;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Period/high-time counters; the rise cycle itself counts as cycle 1.
    always_ff @(posedge clk) begin
        if (rst_n || !ena) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_pcnt <= c_cnt_one;
            r_hcnt <= c_cnt_one;
        end else if ((r_state == HIGH) || (r_state == LOW)) begin
            r_pcnt <= r_pcnt + c_cnt_one;
            if ((r_state == HIGH) && !w_fall) begin
                r_hcnt <= r_hcnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_pend_p <= '0;
            r_pend_h <= '0;
        end else if (w_div_start) begin
            r_pend_p <= r_pcnt;
            r_pend_h <= r_hcnt;
        end
    end

    pwm_div_restoring #(
        .CW (CW)
    ) u_div (
        .clk      (clk),
        .rst      (rst_n),
        .i_abort  (!ena),
        .i_start  (w_div_start),
        .i_num_hi (r_hcnt),
        .i_den    (r_pcnt),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quot   (w_div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_duty    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!ena) begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_sat) begin
                r_valid   <= 1'b1;
                r_timeout <= 1'b1;
                r_period  <= '0;
                r_high    <= '0;
                r_duty    <= w_s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
            end else if (w_div_done) begin
                r_valid  <= 1'b1;
                r_duty   <= w_div_quot;
                r_period <= r_pend_p;
                r_high   <= r_pend_h;
            end
            if ((r_state == STUCK) && w_rise) begin
                r_timeout <= 1'b0;
            end
            if (w_meas && w_div_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign duty      = r_duty;
    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign busy      = w_div_busy;
    assign timeout   = r_timeout;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_pwm_duty_decoder
// Purpose  : Directed self-checking bench for pwm_duty_decoder. One CW=16
//            instance for measurement scenarios, one CW=8 instance for the
//            timeout scenario. Inputs change and outputs are sampled on the
//            falling clock edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_duty_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b1;
    logic        pwm_a = 1'b0;
    logic        pwm_b = 1'b0;

    logic [7:0]  duty_a;
    logic [15:0] period_a, high_a;
    logic        valid_a, busy_a, timeout_a, overrun_a;
    logic [7:0]  duty_b;
    logic [7:0]  period_b, high_b;
    logic        valid_b, busy_b, timeout_b, overrun_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int va_cyc[$], va_duty[$], va_per[$], va_high[$];
    int vb_duty[$], vb_per[$], vb_high[$], vb_to[$];
    int rise_q[$];

    always #5 clk = ~clk;

    pwm_duty_decoder #(.CW(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_a),
        .duty(duty_a), .period(period_a), .high_time(high_a),
        .valid(valid_a), .busy(busy_a), .timeout(timeout_a), .overrun(overrun_a)
    );

    pwm_duty_decoder #(.CW(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_b),
        .duty(duty_b), .period(period_b), .high_time(high_b),
        .valid(valid_b), .busy(busy_b), .timeout(timeout_b), .overrun(overrun_b)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock step: sample and log outputs, then drive the next pin values.
    task automatic step(input logic a, input logic b);
        @(negedge clk);
        cyc++;
        if (valid_a === 1'b1) begin
            va_cyc.push_back(cyc);
            va_duty.push_back(int'(duty_a));
            va_per.push_back(int'(period_a));
            va_high.push_back(int'(high_a));
        end
        if (valid_b === 1'b1) begin
            vb_duty.push_back(int'(duty_b));
            vb_per.push_back(int'(period_b));
            vb_high.push_back(int'(high_b));
            vb_to.push_back(int'(timeout_b));
        end
        if (a && !pwm_a) rise_q.push_back(cyc);
        pwm_a = a;
        pwm_b = b;
    endtask

    task automatic clear_logs();
        va_cyc.delete(); va_duty.delete(); va_per.delete(); va_high.delete();
        vb_duty.delete(); vb_per.delete(); vb_high.delete(); vb_to.delete();
        rise_q.delete();
    endtask

    task automatic do_reset();
        ena = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        rst_n = 1'b0;
        clear_logs();
    endtask

    task automatic wave_a(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
        end
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        tests_run++;
        if ({duty_a, period_a, high_a} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got duty=%0h period=%0h high=%0h required all 0", duty_a, period_a, high_a);
        end
        tests_run++;
        if ({valid_a, busy_a, timeout_a, overrun_a} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got v/b/t/o=%b required 0000", {valid_a, busy_a, timeout_a, overrun_a});
        end
        tests_run++;
        if ({duty_b, valid_b, timeout_b, overrun_b} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset_dut8: got duty=%0h v=%b t=%b o=%b required all 0", duty_b, valid_b, timeout_b, overrun_b);
        end
        rst_n = 1'b0;
        clear_logs();
    endtask

    task automatic test_basic();
        do_reset();
        wave_a(4, 12, 4);
        idle_a(12);
        tests_run++;
        if (va_duty.size() != 3) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d valids required 3", va_duty.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (va_duty[i] != 64 || va_per[i] != 16 || va_high[i] != 4) begin
                    tests_failed++;
                    $display("FAIL basic_meas[%0d]: got duty=%0d period=%0d high=%0d required 64/16/4",
                             i, va_duty[i], va_per[i], va_high[i]);
                end
            end
            tests_run++;
            if (va_cyc[0] != rise_q[1] + 11) begin
                tests_failed++;
                $display("FAIL basic_latency: got valid at %0d required %0d", va_cyc[0], rise_q[1] + 11);
            end
        end
        tests_run++;
        if (overrun_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_overrun: got %b required 0", overrun_a);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        wave_a(1, 255, 3);
        idle_a(12);
        tests_run++;
        if (va_duty.size() != 2 || va_duty[1] != 1 || va_per[1] != 256 || va_high[1] != 1) begin
            tests_failed++;
            $display("FAIL low_duty: got n=%0d duty=%0d period=%0d high=%0d required 2/1/256/1",
                     va_duty.size(), (va_duty.size() > 1) ? va_duty[1] : -1,
                     (va_per.size() > 1) ? va_per[1] : -1, (va_high.size() > 1) ? va_high[1] : -1);
        end
        do_reset();
        wave_a(200, 56, 3);
        idle_a(12);
        tests_run++;
        if (va_duty.size() != 2 || va_duty[1] != 200 || va_per[1] != 256 || va_high[1] != 200) begin
            tests_failed++;
            $display("FAIL high_duty: got n=%0d duty=%0d period=%0d high=%0d required 2/200/256/200",
                     va_duty.size(), (va_duty.size() > 1) ? va_duty[1] : -1,
                     (va_per.size() > 1) ? va_per[1] : -1, (va_high.size() > 1) ? va_high[1] : -1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 270; i++) step(1'b0, 1'b1);
        tests_run++;
        if (vb_duty.size() != 1) begin
            tests_failed++;
            $display("FAIL timeout_count: got %0d valids required 1", vb_duty.size());
        end else begin
            tests_run++;
            if (vb_duty[0] != 255 || vb_per[0] != 0 || vb_high[0] != 0 || vb_to[0] != 1) begin
                tests_failed++;
                $display("FAIL timeout_meas: got duty=%0d period=%0d high=%0d to=%0d required 255/0/0/1",
                         vb_duty[0], vb_per[0], vb_high[0], vb_to[0]);
            end
        end
        tests_run++;
        if (timeout_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_held: got %b required 1", timeout_b);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        tests_run++;
        if (timeout_b !== 1'b0 || vb_duty.size() != 1) begin
            tests_failed++;
            $display("FAIL timeout_clear: got timeout=%b valids=%0d required 0 and 1", timeout_b, vb_duty.size());
        end
    endtask

    task automatic test_overrun();
        do_reset();
        wave_a(3, 3, 8);
        idle_a(20);
        tests_run++;
        if (overrun_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_flag: got %b required 1", overrun_a);
        end
        tests_run++;
        if (va_duty.size() != 4) begin
            tests_failed++;
            $display("FAIL overrun_count: got %0d valids required 4", va_duty.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (va_duty[i] != 128 || va_per[i] != 6 || va_high[i] != 3) begin
                    tests_failed++;
                    $display("FAIL overrun_meas[%0d]: got duty=%0d period=%0d high=%0d required 128/6/3",
                             i, va_duty[i], va_per[i], va_high[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        wave_a(4, 12, 3);
        tests_run++;
        if (duty_a !== 8'd64) begin
            tests_failed++;
            $display("FAIL mid_pre_duty: got %0d required 64", duty_a);
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        tests_run++;
        if (busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_busy: got %b required 1", busy_a);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        tests_run++;
        if ({duty_a, period_a, high_a, valid_a, busy_a, overrun_a} !== 43'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: got duty=%0d period=%0d high=%0d v=%b b=%b required all 0",
                     duty_a, period_a, high_a, valid_a, busy_a);
        end
        rst_n = 1'b0;
        clear_logs();
        idle_a(15);
        tests_run++;
        if (va_duty.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_no_valid: got %0d valids required 0", va_duty.size());
        end
    endtask

    task automatic test_ena();
        do_reset();
        wave_a(4, 12, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        ena = 1'b0;
        clear_logs();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        idle_a(10);
        tests_run++;
        if (busy_a !== 1'b0 || va_duty.size() != 0) begin
            tests_failed++;
            $display("FAIL ena_halt: got busy=%b valids=%0d required 0 and 0", busy_a, va_duty.size());
        end
        tests_run++;
        if (duty_a !== 8'd64 || period_a !== 16'd16 || high_a !== 16'd4) begin
            tests_failed++;
            $display("FAIL ena_hold: got duty=%0d period=%0d high=%0d required 64/16/4", duty_a, period_a, high_a);
        end
        ena = 1'b1;
        wave_a(2, 6, 1);
        idle_a(20);
        tests_run++;
        if (va_duty.size() != 0 || duty_a !== 8'd64) begin
            tests_failed++;
            $display("FAIL ena_rearm: got valids=%0d duty=%0d required 0 and 64", va_duty.size(), duty_a);
        end
    endtask

    task automatic test_jitter();
        int hi_l [6];
        int lo_l [6];
        int exp_duty [5];
        int exp_per [5];
        hi_l     = '{7, 9, 8, 9, 7, 8};
        lo_l     = '{25, 23, 24, 26, 24, 25};
        exp_duty = '{56, 72, 64, 65, 57};
        exp_per  = '{32, 32, 32, 35, 31};
        do_reset();
        for (int k = 0; k < 6; k++) wave_a(hi_l[k], lo_l[k], 1);
        idle_a(20);
        tests_run++;
        if (va_duty.size() != 5) begin
            tests_failed++;
            $display("FAIL jitter_count: got %0d valids required 5", va_duty.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (va_duty[i] != exp_duty[i] || va_per[i] != exp_per[i] || va_high[i] != hi_l[i]) begin
                    tests_failed++;
                    $display("FAIL jitter_meas[%0d]: got duty=%0d period=%0d high=%0d required %0d/%0d/%0d",
                             i, va_duty[i], va_per[i], va_high[i], exp_duty[i], exp_per[i], hi_l[i]);
                end
                tests_run++;
                if (va_cyc[i] != rise_q[i+1] + 11) begin
                    tests_failed++;
                    $display("FAIL jitter_latency[%0d]: got valid at %0d required %0d",
                             i, va_cyc[i], rise_q[i+1] + 11);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_timeout();
        test_overrun();
        test_reset_mid_divide();
        test_ena();
        test_jitter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
